axis_dac_prefill_buffer: RTL and testbench



---
 rtl/axis_dac_prefill_buffer.sv | 158 +++++++++++++++
 tb/tb_axis_dac_prefill_buffer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_dac_prefill_buffer.sv
// Prefill FIFO between the DMA gate stage and the RFDC DAC stream input.
// Holds playback until prefilled, then streams continuously with zero fill.
module axis_dac_prefill_buffer #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 6,
    parameter int PREFILL_LEVEL = 32,
    parameter int FLUSH_TIMEOUT = 16,
    parameter int END_GAP       = 8,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  clear_count,
    output logic [CNT_WIDTH-1:0]  underflow_count,
    output logic [ADDR_WIDTH:0]   fill_level,
    output logic [1:0]            state_o
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int AW1   = ADDR_WIDTH + 1;
    localparam int TW    = $clog2(FLUSH_TIMEOUT + 1);
    localparam int GW    = $clog2(END_GAP + 1);

    localparam logic [ADDR_WIDTH:0] FULL_LVL = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] PRE_LVL  = AW1'(PREFILL_LEVEL);
    localparam logic [TW-1:0]       T_LAST   = TW'(FLUSH_TIMEOUT - 1);
    localparam logic [GW-1:0]       G_LAST   = GW'(END_GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PREFILL = 2'd1,
        S_STREAM  = 2'd2
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_m_tdata;
    logic                  r_run;
    logic [TW-1:0]         r_timer;
    logic [GW-1:0]         r_gap;
    logic [CNT_WIDTH-1:0]  r_ucount;

    logic [ADDR_WIDTH:0]   w_fill;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr;
    logic                  w_beat;
    logic                  w_rd;
    logic                  w_under;
    logic                  w_flush;

    // Extra pointer bit separates full from empty.
    assign w_fill  = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_fill == FULL_LVL);
    assign w_empty = (w_fill == '0);
    assign w_wr    = s_axis_tvalid && s_axis_tready;
    assign w_beat  = r_run && m_axis_tready;
    assign w_rd    = (r_state == S_STREAM) && w_beat && !w_empty;
    assign w_under = (r_state == S_STREAM) && w_beat && w_empty;
    assign w_flush = !w_wr && (r_timer == T_LAST);

    assign s_axis_tready   = r_run && !w_full;
    assign m_axis_tvalid   = r_run;
    assign m_axis_tdata    = r_m_tdata;
    assign underflow_count = r_ucount;
    assign fill_level      = w_fill;
    assign state_o         = r_state;

    always_ff @(posedge aclk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= s_axis_tdata;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state   <= S_IDLE;
            r_run     <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_m_tdata <= '0;
            r_timer   <= '0;
            r_gap     <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case (r_state)
                S_IDLE: begin
                    r_timer <= '0;
                    r_gap   <= '0;
                    if (w_beat) begin
                        r_m_tdata <= '0;
                    end
                    if (!w_empty) begin
                        r_state <= S_PREFILL;
                    end
                end
                S_PREFILL: begin
                    if (w_beat) begin
                        r_m_tdata <= '0;
                    end
                    if (w_wr) begin
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                    // Timer value FLUSH_TIMEOUT is reached on this edge.
                    if (w_fill >= PRE_LVL || w_flush) begin
                        r_state <= S_STREAM;
                        r_timer <= '0;
                    end
                end
                S_STREAM: begin
                    if (w_beat) begin
                        if (!w_empty) begin
                            r_m_tdata <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
                            r_gap     <= '0;
                        end else begin
                            r_m_tdata <= '0;
                            if (r_gap == G_LAST) begin
                                r_gap   <= '0;
                                r_state <= S_IDLE;
                            end else begin
                                r_gap <= r_gap + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_ucount <= '0;
        end else if (clear_count) begin
            r_ucount <= '0;
        end else if (w_under && r_gap == '0 && r_ucount != '1) begin
            r_ucount <= r_ucount + 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_dac_prefill_buffer.sv
// Directed bench for axis_dac_prefill_buffer.
// Expected values are hand-derived cycle counts and word sequences.
module tb_axis_dac_prefill_buffer;

    logic        aclk = 1'b0;
    logic        areset;
    logic [15:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        clear_count;
    logic [15:0] underflow_count;
    logic [6:0]  fill_level;
    logic [1:0]  state_o;

    int          n_total = 0;
    int          n_bad = 0;
    bit          rec_en = 1'b0;
    logic [15:0] rx[$];
    logic [15:0] exp_q[$];

    axis_dac_prefill_buffer dut (
        .aclk            (aclk),
        .areset          (areset),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .clear_count     (clear_count),
        .underflow_count (underflow_count),
        .fill_level      (fill_level),
        .state_o         (state_o)
    );

    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Each edge with tready high is a beat; record the word it loaded.
    task automatic step();
        @(posedge aclk);
        #1;
        if (rec_en && m_axis_tready && m_axis_tvalid) begin
            rx.push_back(m_axis_tdata);
        end
    endtask

    task automatic send(input logic [15:0] d);
        int t;
        t = 0;
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && t < 200) begin
            step();
            t++;
        end
        chk("send_wait", 32'(t >= 200), 0);
        step();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int t;
        t = 0;
        while (state_o != 2'd0 && t < budget) begin
            step();
            t++;
        end
        chk({tag, "_idle"}, 32'(state_o), 0);
    endtask

    task automatic check_stream(input string tag, input int exp_int,
                                input int exp_trail);
        logic [15:0] nz[$];
        int first;
        int last;
        int zin;
        int bad;
        first = -1;
        last  = -1;
        zin   = 0;
        bad   = 0;
        for (int i = 0; i < rx.size(); i++) begin
            if (rx[i] != 16'h0) begin
                if (first < 0) first = i;
                last = i;
                nz.push_back(rx[i]);
            end
        end
        if (first >= 0) begin
            for (int i = first; i <= last; i++) begin
                if (rx[i] == 16'h0) zin++;
            end
        end
        chk({tag, "_len"}, nz.size(), exp_q.size());
        for (int i = 0; i < nz.size() && i < exp_q.size(); i++) begin
            if (nz[i] !== exp_q[i]) bad++;
        end
        chk({tag, "_order"}, bad, 0);
        chk({tag, "_gap"}, zin, exp_int);
        chk({tag, "_tail"}, rx.size() - 1 - last, exp_trail);
    endtask

    initial begin
        int n;
        int z;
        bit seen;
        areset        = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        clear_count   = 1'b0;

        // Reset
        for (int i = 0; i < 5; i++) step();
        chk("rst_mvalid", 32'(m_axis_tvalid), 0);
        chk("rst_mdata", 32'(m_axis_tdata), 0);
        chk("rst_sready", 32'(s_axis_tready), 0);
        chk("rst_fill", 32'(fill_level), 0);
        chk("rst_state", 32'(state_o), 0);
        chk("rst_count", 32'(underflow_count), 0);
        areset = 1'b0;
        step();
        chk("post_mvalid", 32'(m_axis_tvalid), 1);
        chk("post_mdata", 32'(m_axis_tdata), 0);
        chk("post_state", 32'(state_o), 0);
        chk("post_sready", 32'(s_axis_tready), 1);

        // Prefill by level
        rec_en = 1'b1;
        rx.delete();
        for (int i = 1; i <= 40; i++) begin
            send(16'(i));
            if (i == 2) chk("t1_prefill", 32'(state_o), 1);
            if (i == 32) begin
                chk("t1_fill32", 32'(fill_level), 32);
                chk("t1_st32", 32'(state_o), 1);
            end
            if (i == 33) begin
                chk("t1_st33", 32'(state_o), 2);
                chk("t1_fill33", 32'(fill_level), 33);
            end
            if (i == 34) begin
                chk("t1_pushpop", 32'(fill_level), 33);
                chk("t1_first", 32'(m_axis_tdata), 1);
            end
        end
        s_axis_tvalid = 1'b0;
        wait_idle("t1", 200);
        exp_q.delete();
        for (int i = 1; i <= 40; i++) exp_q.push_back(16'(i));
        check_stream("t1", 0, 8);
        chk("t1_count", 32'(underflow_count), 1);

        // Flush timeout
        rx.delete();
        for (int i = 1; i <= 5; i++) send(16'(16'hA0 + i));
        s_axis_tvalid = 1'b0;
        n = 0;
        while (state_o != 2'd2 && n < 40) begin
            step();
            n++;
        end
        chk("t2_flush_cycles", n, 16);
        wait_idle("t2", 100);
        exp_q.delete();
        for (int i = 1; i <= 5; i++) exp_q.push_back(16'(16'hA0 + i));
        check_stream("t2", 0, 8);
        chk("t2_count", 32'(underflow_count), 2);

        // Backpressure and full
        m_axis_tready = 1'b0;
        rx.delete();
        for (int i = 1; i <= 64; i++) send(16'(16'h100 + i));
        chk("t3_full_fill", 32'(fill_level), 64);
        chk("t3_full_rdy", 32'(s_axis_tready), 0);
        chk("t3_state", 32'(state_o), 2);
        chk("t3_hold_data", 32'(m_axis_tdata), 0);
        s_axis_tdata  = 16'h141;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("t3_held_fill", 32'(fill_level), 64);
        chk("t3_held_rdy", 32'(s_axis_tready), 0);
        m_axis_tready = 1'b1;
        step();
        chk("t3_rel_fill", 32'(fill_level), 63);
        chk("t3_rel_data", 32'(m_axis_tdata), 16'h101);
        chk("t3_rel_rdy", 32'(s_axis_tready), 1);
        send(16'h141);
        chk("t3_pushpop", 32'(fill_level), 63);
        for (int i = 66; i <= 70; i++) send(16'(16'h100 + i));
        s_axis_tvalid = 1'b0;
        wait_idle("t3", 300);
        exp_q.delete();
        for (int i = 1; i <= 70; i++) exp_q.push_back(16'(16'h100 + i));
        check_stream("t3", 0, 8);
        chk("t3_count", 32'(underflow_count), 3);

        // Gap counting
        clear_count = 1'b1;
        step();
        clear_count = 1'b0;
        chk("t4_clear", 32'(underflow_count), 0);
        rx.delete();
        for (int i = 1; i <= 4; i++) send(16'(16'hB0 + i));
        s_axis_tvalid = 1'b0;
        z = 0;
        n = 0;
        seen = 1'b0;
        while (z < 2 && n < 100) begin
            step();
            n++;
            if (m_axis_tdata == 16'hB4) seen = 1'b1;
            else if (seen && m_axis_tdata == 16'h0) z++;
        end
        chk("t4_wait", 32'(n >= 100), 0);
        send(16'hC1);
        chk("t4_count1", 32'(underflow_count), 1);
        for (int i = 2; i <= 4; i++) send(16'(16'hC0 + i));
        s_axis_tvalid = 1'b0;
        wait_idle("t4", 100);
        exp_q.delete();
        for (int i = 1; i <= 4; i++) exp_q.push_back(16'(16'hB0 + i));
        for (int i = 1; i <= 4; i++) exp_q.push_back(16'(16'hC0 + i));
        check_stream("t4", 3, 8);
        chk("t4_count2", 32'(underflow_count), 2);

        // Clear coinciding with a gap start
        rx.delete();
        send(16'hD1);
        send(16'hD2);
        s_axis_tvalid = 1'b0;
        n = 0;
        while (m_axis_tdata != 16'hD2 && n < 100) begin
            step();
            n++;
        end
        chk("t5_wait", 32'(n >= 100), 0);
        clear_count = 1'b1;
        step();
        clear_count = 1'b0;
        chk("t5_clr_prio", 32'(underflow_count), 0);
        chk("t5_zero", 32'(m_axis_tdata), 0);
        wait_idle("t5", 50);
        chk("t5_count", 32'(underflow_count), 0);
        exp_q.delete();
        exp_q.push_back(16'hD1);
        exp_q.push_back(16'hD2);
        check_stream("t5", 0, 8);

        // Reset mid-burst
        m_axis_tready = 1'b0;
        for (int i = 1; i <= 20; i++) send(16'(16'h200 + i));
        s_axis_tvalid = 1'b0;
        chk("t6_fill", 32'(fill_level), 20);
        chk("t6_state", 32'(state_o), 1);
        areset = 1'b1;
        #1;
        chk("t6_rst_fill", 32'(fill_level), 0);
        chk("t6_rst_state", 32'(state_o), 0);
        chk("t6_rst_mvalid", 32'(m_axis_tvalid), 0);
        chk("t6_rst_sready", 32'(s_axis_tready), 0);
        chk("t6_rst_data", 32'(m_axis_tdata), 0);
        step();
        step();
        areset = 1'b0;
        m_axis_tready = 1'b1;
        rx.delete();
        for (int i = 0; i < 40; i++) step();
        n = 0;
        foreach (rx[i]) if (rx[i] != 16'h0) n++;
        chk("t6_beats", rx.size(), 40);
        chk("t6_stale", n, 0);
        chk("t6_post_fill", 32'(fill_level), 0);
        chk("t6_post_state", 32'(state_o), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
